mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter for the PYNQ-Z2 build; drives the board uart_tx pin.

---
 rtl/mmio_uart_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Registers (byte addresses):
//   BASE_ADDR     DATA   (write-only) a store with be[0]=1 pushes wdata[7:0]
//   BASE_ADDR+4   STATUS [0]=fifo_full [1]=fifo_empty [2]=tx_busy [3]=overflow (sticky)
//                        a store with be[0]=1 and wdata[3]=1 clears overflow
//
// Ports:
//   clk        cpu clock
//   rst_n      synchronous reset, active-low
//   bus_addr   byte address from the CPU MEM stage
//   bus_we     store strobe, one cycle per store
//   bus_be     store byte enables
//   bus_wdata  store data
//   bus_rdata  STATUS read data, registered (0 when the address misses)
//   bus_rsel   registered; 1 when the previous cycle's address hit STATUS
//   tx         serial line, idle high, registered
//   tx_busy    1 while the FIFO holds data or a frame is being sent
module mmio_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic        bus_we,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rsel,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned ClksPerBit = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW     = PtrW + 1;

  localparam logic [31:0]       StatusAddr = BASE_ADDR + 32'd4;
  localparam logic [CntW-1:0]   BcntMax    = CntW'(ClksPerBit - 1);
  localparam logic [CountW-1:0] CountFull  = CountW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // State registers
  state_e            state_q, state_d;
  logic [CntW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rsel_q, rsel_d;

  logic [7:0] mem_q [FIFO_DEPTH];

  // Decode and FIFO control
  logic hit_data, hit_status;
  logic push_req, push, pop, drop, ovf_clear;
  logic fifo_full, fifo_empty;
  logic bcnt_last;
  logic [31:0] status;

  // Byte lanes above 0 carry nothing for either register.
  logic unused_bits;
  assign unused_bits = ^{bus_be[3:1], bus_wdata[31:8]};

  assign hit_data   = (bus_addr == BASE_ADDR);
  assign hit_status = (bus_addr == StatusAddr);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CountFull);
  assign push_req   = bus_we & hit_data & bus_be[0];
  assign ovf_clear  = bus_we & hit_status & bus_be[0] & bus_wdata[3];
  // The FSM only takes a byte while idle; that pop frees a slot for a same-cycle push.
  assign pop        = (state_q == StIdle) & ~fifo_empty;
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;
  assign bcnt_last  = (bcnt_q == BcntMax);

  assign status = {28'd0, overflow_q, busy_q, fifo_empty, fifo_full};

  // FIFO bookkeeping and bus-side registers
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rdata_d    = 32'd0;
    rsel_d     = 1'b0;

    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase

    // A dropped byte wins over a clear in the same cycle so no loss goes unreported.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end

    if (hit_status) begin
      rdata_d = status;
      rsel_d  = 1'b1;
    end
  end

  // Transmit FSM next-state and line output
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          bcnt_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bcnt_last) begin
          bcnt_d  = '0;
          bidx_d  = 3'd0;
          state_d = StData;
        end else begin
          bcnt_d = bcnt_q + CntW'(1);
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bcnt_last) begin
          bcnt_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bidx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + CntW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bcnt_last) begin
          bcnt_d  = '0;
          state_d = StIdle;
        end else begin
          bcnt_d = bcnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (count_d != '0) | (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bcnt_q     <= '0;
      bidx_q     <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rdata_q    <= 32'd0;
      rsel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      rsel_q     <= rsel_d;
    end
  end

  // Storage needs no reset; count/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= bus_wdata[7:0];
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign bus_rdata = rdata_q;
  assign bus_rsel  = rsel_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx.
// Runs with CLKS_PER_BIT = 4 (CLK_FREQ_HZ=4, BAUD=1), FIFO_DEPTH = 8.
module tb_mmio_uart_tx;

  localparam logic [31:0] Base     = 32'h8000_0010;
  localparam logic [31:0] StatAddr = 32'h8000_0014;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rsel;
  logic        tx;
  logic        tx_busy;

  mmio_uart_tx #(
    .CLK_FREQ_HZ(4),
    .BAUD       (1),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (Base)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_be   (bus_be),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_rsel (bus_rsel),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: decodes frames at mid-bit (negedge), aborts on reset.
  logic [7:0] mon_data[$];
  int         mon_time[$];
  logic       mon_stop[$];

  initial begin : line_mon
    logic [7:0] d;
    int         t0;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        d = 8'h00;
        for (int c = 1; c <= 37; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c >= 5 && c <= 33 && ((c - 5) % 4) == 0) d[(c - 5) / 4] = tx;
        end
        if (!aborted) begin
          mon_data.push_back(d);
          mon_time.push_back(t0);
          mon_stop.push_back(tx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    bus_addr  = addr;
    bus_be    = be;
    bus_wdata = data;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    bus_addr = StatAddr;
    bus_we   = 1'b0;
    tick();
    check_eq({tag, "_rsel"}, bus_rsel, 1'b1);
    check_eq(tag, bus_rdata, exp);
    bus_addr = 32'd0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (tx_busy === 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq(tag, tx_busy, 1'b0);
  endtask

  // Expected line level k cycles after the push edge of a single frame.
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k < 2) return 1'b1;
    if (k <= 5) return 1'b0;
    if (k <= 37) return b[(k - 6) / 4];
    return 1'b1;
  endfunction

  initial begin
    rst_n     = 1'b0;
    bus_addr  = 32'd0;
    bus_we    = 1'b0;
    bus_be    = 4'd0;
    bus_wdata = 32'd0;
    tick();
    tick();
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    check_eq("rst_rdata", bus_rdata, 32'd0);
    check_eq("rst_rsel", bus_rsel, 1'b0);
    rst_n = 1'b1;
    tick();
    read_status("rst_status", 32'h2);

    // 1) single frame of 0xA5, cycle by cycle
    store(Base, 4'hF, 32'h0000_00A5);
    check_eq("t1_busy_rise", tx_busy, 1'b1);
    for (int k = 1; k <= 42; k++) begin
      tick();
      check_eq($sformatf("t1_tx_k%0d", k), tx, exp_tx(k, 8'hA5));
      if (k == 40) check_eq("t1_busy_k40", tx_busy, 1'b1);
      if (k == 41) check_eq("t1_busy_k41", tx_busy, 1'b0);
    end
    check_eq("t1_nframes", mon_data.size(), 1);
    if (mon_data.size() == 1) check_eq("t1_data", mon_data[0], 8'hA5);
    mon_data.delete(); mon_time.delete(); mon_stop.delete();

    // 2) back-to-back A, B, C
    store(Base, 4'h1, 32'h41);
    store(Base, 4'h1, 32'h42);
    store(Base, 4'h1, 32'h43);
    wait_idle("t2_idle", 400);
    repeat (3) tick();
    check_eq("t2_nframes", mon_data.size(), 3);
    if (mon_data.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("t2_data%0d", i), mon_data[i], 32'h41 + i);
        check_eq($sformatf("t2_stop%0d", i), mon_stop[i], 1'b1);
      end
      check_eq("t2_gap01", mon_time[1] - mon_time[0], 41);
      check_eq("t2_gap12", mon_time[2] - mon_time[1], 41);
    end
    mon_data.delete(); mon_time.delete(); mon_stop.delete();

    // 3) 10 stores: one popped, 8 buffered, last dropped
    for (int i = 0; i < 10; i++) store(Base, 4'h1, 32'h30 + i);
    // full | busy | overflow = 0x1 + 0x4 + 0x8
    read_status("t3_status_full", 32'hD);
    wait_idle("t3_idle", 2000);
    repeat (60) tick();
    check_eq("t3_nframes", mon_data.size(), 9);
    if (mon_data.size() == 9) begin
      for (int i = 0; i < 9; i++) check_eq($sformatf("t3_data%0d", i), mon_data[i], 32'h30 + i);
    end
    read_status("t3_status_ovf", 32'hA);
    store(StatAddr, 4'h1, 32'h8);
    read_status("t3_status_clr", 32'h2);
    mon_data.delete(); mon_time.delete(); mon_stop.delete();

    // 4) be[0]=0 store is ignored
    store(Base, 4'b0010, 32'h0000_5555);
    check_eq("t4_busy", tx_busy, 1'b0);
    repeat (20) tick();
    check_eq("t4_tx", tx, 1'b1);
    check_eq("t4_nframes", mon_data.size(), 0);
    read_status("t4_status", 32'h2);

    // 5) reset during data bit 3, then a clean frame
    store(Base, 4'h1, 32'h3C);
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    check_eq("t5_tx", tx, 1'b1);
    check_eq("t5_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    read_status("t5_status", 32'h2);
    repeat (5) tick();
    check_eq("t5_aborted", mon_data.size(), 0);
    store(Base, 4'h1, 32'h96);
    wait_idle("t5_idle", 200);
    repeat (3) tick();
    check_eq("t5_nframes", mon_data.size(), 1);
    if (mon_data.size() == 1) begin
      check_eq("t5_data", mon_data[0], 8'h96);
      check_eq("t5_stop", mon_stop[0], 1'b1);
    end
    mon_data.delete(); mon_time.delete(); mon_stop.delete();

    // 6) STATUS read mid-frame, then a miss
    store(Base, 4'h1, 32'h11);
    repeat (10) tick();
    read_status("t6_status", 32'h6);
    bus_addr = Base;
    tick();
    check_eq("t6_miss_rsel", bus_rsel, 1'b0);
    check_eq("t6_miss_rdata", bus_rdata, 32'd0);
    bus_addr = 32'd0;
    wait_idle("t6_idle", 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
